// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/baud settings.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = IDLE,
        StStart  = START,
        StData   = DATA,
        StParity = PARITY,
        StStop   = STOP
    } rx_state_e;

    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned BAUDRATE       = 9600;
    localparam int unsigned CLK_HZ         = 100_000_000;

    // Clocks per oversampling tick; consumed by the baud tick generator.
    localparam int unsigned TICK_DIV = CLK_HZ / (BAUDRATE * OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw RX pin plus a delayed copy for falling-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_edge_o
);

    logic meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    // Idle-high line: flops reset to 1 so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            meta_q    <= rx_i;
            rx_s_q    <= meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_s_o      = rx_s_q;
    assign fall_edge_o = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, idle-high line, 8N1 by default.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop, reported on parity_err_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_done_o,
    output logic                 frame_err_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;
    logic fall_edge;

    uart_rx_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .rx_s_o      (rx_s),
        .fall_edge_o (fall_edge)
    );

    rx_state_e            state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_done_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q;
    logic                 parity_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // b_tick is deliberately ignored here; counting starts in StStart.
                    if (fall_edge) begin
                        state_q    <= StStart;
                        tick_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (b_tick_i) begin
                        if (tick_cnt_q == TICK_HALF) begin
                            if (!rx_s) begin
                                state_q    <= StData;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                StData: begin
                    if (b_tick_i) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                            tick_cnt_q <= '0;
                            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= StParity;
`else
                                state_q <= StStop;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (b_tick_i) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            parity_bit_q <= rx_s;
                            tick_cnt_q   <= '0;
                            state_q      <= StStop;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
`endif
                StStop: begin
                    // Leave mid stop bit so an immediately following start edge is not missed.
                    if (b_tick_i) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            rx_data_q    <= shift_q;
                            frame_err_q  <= ~rx_s;
                            rx_done_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= parity_bit_q ^ (^shift_q);
`endif
                            tick_cnt_q   <= '0;
                            state_q      <= StIdle;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_done_o   = rx_done_q;
    assign frame_err_o = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized frames against a frame-level reference model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS = OVERSAMPLE_DEF;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    int n_vec = 0;
    int n_err = 0;
    int tick_div = 4;
    int tick_ctr = 0;
    rec_t got_q[$];
    rec_t exp_q[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .b_tick_i     (b_tick),
        .rx_i         (rx),
        .rx_data_o    (rx_data),
        .rx_done_o    (rx_done),
        .frame_err_o  (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o (parity_err)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_ctr = tick_ctr + 1;
            if (tick_ctr >= tick_div) begin
                tick_ctr = 0;
                b_tick = 1'b1;
            end else begin
                b_tick = 1'b0;
            end
        end
    end

    // Every clock in which rx_done is high is one delivered frame.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) got_q.push_back({rx_data, frame_err, parity_err});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d want finish", n_vec);
        $fatal(1);
    end

    // Reference: a frame delivers its data, ferr = stop bit low, perr = even-parity violation.
    function automatic rec_t model(input logic [7:0] d, input logic stop_v, input logic par_v);
        rec_t r;
        r.data = d;
        r.ferr = ~stop_v;
        r.perr = PAR_EN ? (par_v ^ (^d)) : 1'b0;
        return r;
    endfunction

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (b_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic v);
        #1 rx = v;
        wait_ticks(OS);
    endtask

    task automatic idle_bits(input int n);
        #1 rx = 1'b1;
        wait_ticks(n * OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        exp_q.push_back(model(d, stop_v, par_v));
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par_v);
        send_bit(stop_v);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", rx_data); end
        n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", rx_done); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b want 0", parity_err); end
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_basic;
        tick_div = int'($urandom_range(3, 6));
        send_frame(8'h30, 1'b1, 1'b0);
        idle_bits(2);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL basic_frame got %h want %h", got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (rx_data !== 8'h30) begin n_err++; $display("FAIL basic_hold got %h want 30", rx_data); end
        n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL basic_pulse got %b want 0", rx_done); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        tick_div = int'($urandom_range(3, 6));
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'($urandom));
        end
        idle_bits(2);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b_frame%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch;
        tick_div = int'($urandom_range(3, 6));
        #1 rx = 1'b0;
        wait_ticks(4);
        idle_bits(2);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL glitch_count got %0d want 0", got_q.size()); end
        n_vec++; if (dut.state_q !== StIdle) begin n_err++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, StIdle); end
        got_q.delete();
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_bits(1);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL glitch_after_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL glitch_after_frame got %h want %h", got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_break;
        tick_div = int'($urandom_range(3, 5));
        send_frame(8'hA5, 1'b0, 1'b0);
        #1 rx = 1'b0;
        wait_ticks(20 * OS);
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL break_count got %0d want 1", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] !== exp_q[0]) begin
                n_err++; $display("FAIL break_frame got %h want %h", got_q[0], exp_q[0]);
            end
        end
        got_q.delete(); exp_q.delete();
        idle_bits(2);
        send_frame(8'h01, 1'b1, 1'b1);
        idle_bits(1);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL break_recover_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL break_recover_frame got %h want %h", got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        tick_div = int'($urandom_range(3, 6));
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #1 rx = 1'b1;
        wait_ticks(OS / 2);
        rst = 1'b1;
        #1;
        n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data got %h want 00", rx_data); end
        n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", rx_done); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ferr got %b want 0", frame_err); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(5);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", got_q.size()); end
        got_q.delete();
        send_frame(8'h0F, 1'b1, 1'b0);
        idle_bits(1);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rstmid_after_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rstmid_after_frame got %h want %h", got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_frames;
        logic [7:0] d;
        logic       stop_v;
        tick_div = int'($urandom_range(3, 6));
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            stop_v = 1'($urandom);
            send_frame(d, stop_v, 1'($urandom));
            // A low stop bit needs the line back high before the next start edge can exist.
            if (!stop_v || $urandom_range(0, 1) == 1) idle_bits(1);
        end
        idle_bits(1);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL random_frame%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        tick_div = 4;
        send_frame(8'h30, 1'b1, 1'b0);
        send_frame(8'h30, 1'b1, 1'b1);
        idle_bits(1);
        n_vec++;
        if (got_q.size() != 2) begin
            n_err++; $display("FAIL parity_count got %0d want 2", got_q.size());
        end else begin
            n_vec++; if (got_q[0].perr !== 1'b0) begin n_err++; $display("FAIL parity_ok got %b want 0", got_q[0].perr); end
            n_vec++; if (got_q[1].perr !== 1'b1) begin n_err++; $display("FAIL parity_bad got %b want 1", got_q[1].perr); end
            n_vec++; if (got_q[1].data !== 8'h30) begin n_err++; $display("FAIL parity_data got %h want 30", got_q[1].data); end
        end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_random_frames();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
